// File: rtl/encoder_32bit_bit_scheduler.sv
// Bit scheduler: accepts a request word and emits the index of each set bit,
// lowest first, one beat per output handshake.
//
// state  | meaning
// IDLE   | waiting for a request word; in_ready high
// EMIT   | presenting index of lowest pending set bit
// ZERO   | presenting the single empty beat for an all-zero word
module encoder_32bit_bit_scheduler #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_empty,
  output logic [CNT_W-1:0] out_cnt,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_ZERO = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] pend_m1;
  logic [WIDTH-1:0] low_bit;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] enc_idx;
  logic             pend_single;
  logic             in_xfer;
  logic             out_xfer;

  // pending is never zero in EMIT, so the decrement cannot wrap where it matters.
  assign pend_m1     = pending - WIDTH'(1);
  assign low_bit     = pending & ~pend_m1;
  assign pend_single = (pending & pend_m1) == '0;

  always_comb begin
    enc_idx = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (low_bit[k]) enc_idx = enc_idx | IDX_W'(k);
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_EMIT) || (state == S_ZERO);
  assign busy      = (state != S_IDLE);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // Outputs decode only registered state, so they hold while the consumer stalls.
  assign out_idx   = (state == S_EMIT) ? enc_idx : '0;
  assign out_last  = (state == S_EMIT) ? pend_single : (state == S_ZERO);
  assign out_empty = (state == S_ZERO);
  assign out_cnt   = (state == S_EMIT) ? cnt + CNT_W'(1) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pending <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_xfer) begin
            pending <= in_req;
            cnt     <= '0;
            state   <= (in_req != '0) ? S_EMIT : S_ZERO;
          end
        end
        S_EMIT: begin
          if (out_xfer) begin
            pending <= pending & pend_m1;
            cnt     <= cnt + CNT_W'(1);
            if (pend_single) state <= S_IDLE;
          end
        end
        S_ZERO: begin
          if (out_xfer) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/encoder_32bit_bit_scheduler.md
Name: encoder_32bit_bit_scheduler

Overview:
- Sequential scheduler around a 32-to-5 index encoder.
- Accepts a 32-bit request word and emits, one beat per cycle, the 5-bit index of every set bit in ascending order, with a last-beat flag.
- Sits between a request source, such as a garbled-circuit frame loader, and a downstream consumer that services one index at a time.
- Uses valid/ready handshakes on both sides so either side can stall.

Parameters:
WIDTH, 32, request word width; must be a power of two.
IDX_W, 5, index width; equals log2(WIDTH).
CNT_W, 6, beat-count width; equals IDX_W+1.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  request word present on in_req.
in_ready  output  1  block can accept a word this cycle.
in_req  input  WIDTH  request word; bit k maps to index k.
out_valid  output  1  out_idx and out_last are valid.
out_ready  input  1  consumer accepts the current beat.
out_idx  output  IDX_W  index of the lowest pending set bit.
out_last  output  1  current beat is the final beat for this word.
out_empty  output  1  the accepted word was all-zero; no index is meaningful.
out_cnt  output  CNT_W  running beat number within the word, 1-based; 0 on an empty beat.
busy  output  1  a word is held (state not IDLE).

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE and the pending register clears to 0.
  - in_ready=1; out_valid=0; out_idx=0; out_last=0; out_empty=0; out_cnt=0; busy=0.
  - Reset overrides any handshake in the same cycle; a word or beat in flight is dropped with no output.
- Transfer rules:
  - Input transfer happens when in_valid & in_ready at an edge.
  - Output transfer happens when out_valid & out_ready at an edge.
  - Outputs are registered: out_idx, out_last, out_empty and out_cnt are stable while out_valid=1 and out_ready=0.
- States:
  - IDLE: in_ready=1, out_valid=0.
    - On input transfer: pending <= in_req, cnt <= 0.
    - Next state is EMIT if in_req != 0, else ZERO.
  - EMIT: in_ready=0, out_valid=1.
    - out_idx = index of the lowest set bit of pending.
    - out_last = 1 when pending has exactly one set bit, i.e. (pending & (pending-1)) == 0.
    - out_cnt = cnt+1; out_empty=0.
    - On output transfer: pending <= pending & (pending-1) and cnt <= cnt+1. Go to IDLE if out_last, else stay in EMIT.
  - ZERO: in_ready=0, out_valid=1, out_empty=1, out_last=1, out_idx=0, out_cnt=0.
    - On output transfer: go to IDLE.
- Latency:
  - First beat appears on out_valid the cycle after the input transfer.
  - With out_ready held at 1, a word with N set bits occupies N cycles of output, then IDLE for one cycle before the next accept.
  - No input/output overlap: in_ready=0 whenever busy. This bubble is intentional and keeps the control simple.
- Arithmetic:
  - pending-1 is computed on WIDTH bits; pending is never 0 in EMIT, so there is no wrap.
  - cnt saturates naturally: the maximum is WIDTH, which fits in CNT_W.
- Boundary conditions:
  - All-ones word gives 32 beats, indices 0..31; out_cnt runs 1..32; out_last only on index 31.
  - Single-bit word gives one beat with out_last=1, out_cnt=1.
  - Bit 31 only gives out_idx=31.
  - in_valid asserted while busy is ignored; the source must hold in_req until in_ready.
  - out_ready low holds the current beat indefinitely; pending is unchanged.
  - Changes on in_req while in EMIT have no effect.
- Index encoder:
  - Must agree with the standalone 32-bit encoder for any one-hot input.
  - out_idx equals that encoder's output applied to the isolated lowest bit, pending & ~(pending-1).

Test Plan:
1. Reset mid-word: accept 0x0000_00F0, consume 2 beats, assert rst -> next cycle out_valid=0, in_ready=1, busy=0; next word 0x1 yields out_idx=0, out_last=1, out_cnt=1.
2. Sparse word: in_req=0x8000_0005, out_ready=1 -> beats idx 0,2,31; out_cnt 1,2,3; out_last only on idx 31; in_ready returns 1 the cycle after the last beat.
3. All-zero word: in_req=0x0 -> exactly one beat with out_empty=1, out_last=1, out_cnt=0, then IDLE.
4. All-ones word under backpressure: in_req=0xFFFF_FFFF, out_ready toggled 1,0,1,0 -> 32 beats idx 0..31 in order, none skipped or duplicated, outputs stable during out_ready=0; out_last on idx 31, out_cnt=32.
5. Input ignored while busy: accept 0x0000_0300, hold in_valid=1 with in_req=0xFFFF_FFFF during emission -> only idx 8,9 emitted; the new word is accepted on the first IDLE cycle.
6. One-hot sweep: for k=0..31 send 1<<k -> a single beat with out_idx=k, out_last=1, matching the standalone encoder's output for the same input.
